vliw_bundle_fetch: RTL

- Fetch front-end of the VLIW processor. Reads 320-bit instruction bundles from the instruction memory on successive bundle indices.
- Buffers bundles in a small prefetch queue and presents them to the decode/issue stage over a valid/ready handshake.
- Tags each bundle with its index and a per-slot occupancy mask.
- Handles redirects (branch/jump) by flushing and restarting at a new index.

---
 rtl/vliw_bundle_fetch_if.sv | 33 +++
 rtl/vliw_bundle_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_fetch_if.sv
// Instruction-memory read port and decode-side bundle handshake of the VLIW fetch unit.
// master = fetch unit, slave = memory/decode environment.
interface vliw_bundle_fetch_if #(
    parameter int NSLOT  = 10,
    parameter int SLOT_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BUNDLE_W = NSLOT * SLOT_W;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic [BUNDLE_W-1:0] imem_rdata;

    logic                bundle_valid;
    logic [BUNDLE_W-1:0] bundle;
    logic [ADDR_W-1:0]   bundle_pc;
    logic [NSLOT-1:0]    slot_mask;
    logic                bundle_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output bundle_valid, bundle, bundle_pc, slot_mask,
        input  bundle_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  bundle_valid, bundle, bundle_pc, slot_mask,
        output bundle_ready
    );
endinterface

// File: rtl/vliw_bundle_fetch.sv
// VLIW fetch front-end: requests bundles by index, buffers them in a small prefetch
// FIFO and hands them to decode tagged with index and per-slot occupancy mask.
module vbf_slot_nz #(
    parameter int SLOT_W = 32
) (
    input  logic [SLOT_W-1:0] slot,
    output logic              nz
);
    assign nz = |slot;
endmodule

module vliw_bundle_fetch #(
    parameter int                NSLOT    = 10,
    parameter int                SLOT_W   = 32,
    parameter int                BUNDLE_W = NSLOT * SLOT_W,
    parameter int                ADDR_W   = 32,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] MAX_PC   = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    vliw_bundle_fetch_if.master bus,
    output logic [ADDR_W-1:0]   fetch_pc,
    output logic                halted
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic [BUNDLE_W-1:0] data;
    } entry_t;

    state_t            state, state_nxt;
    entry_t            q [QDEPTH];
    logic [PW-1:0]     rptr, wptr;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              inflight;
    logic [ADDR_W-1:0] req_pc;
    logic              req, flush, push, pop, bvalid;
    logic [BUNDLE_W-1:0] head_data;
    logic [NSLOT-1:0]  mask;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bvalid = (count != '0);
    assign pop    = bvalid & bus.bundle_ready;
    // A redirect kills the queue and the response landing this cycle; IDLE only reloads the index.
    assign flush  = redirect_valid && (state != IDLE);
    assign push   = inflight && !flush;
    // Occupancy counts slots already promised to outstanding requests.
    assign occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fetch_en) state_nxt = RUN;
            RUN: begin
                if (!fetch_en)                                 state_nxt = IDLE;
                else if (!redirect_valid && fetch_pc > MAX_PC) state_nxt = HALT;
            end
            HALT: begin
                if (!fetch_en)                                     state_nxt = IDLE;
                else if (redirect_valid && redirect_pc <= MAX_PC)  state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        req    = 1'b0;
        halted = (state == HALT);
        if (state == RUN && fetch_en && !redirect_valid && fetch_pc <= MAX_PC &&
            occ < (CW+1)'(QDEPTH))
            req = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= req;
            if (req) req_pc <= fetch_pc;
            if (redirect_valid) fetch_pc <= redirect_pc;
            else if (req)       fetch_pc <= fetch_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[wptr] <= '{pc: req_pc, data: bus.imem_rdata};
    end

    assign head_data        = bvalid ? q[rptr].data : '0;
    assign bus.bundle       = head_data;
    assign bus.bundle_pc    = bvalid ? q[rptr].pc : '0;
    assign bus.bundle_valid = bvalid;
    assign bus.imem_req     = req;
    assign bus.imem_addr    = fetch_pc;
    assign bus.slot_mask    = mask;

    // slot 0 occupies the MSBs of the bundle
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        vbf_slot_nz #(.SLOT_W(SLOT_W)) u_nz (
            .slot (head_data[BUNDLE_W-1-k*SLOT_W -: SLOT_W]),
            .nz   (mask[k])
        );
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(QDEPTH)));
endmodule
